// File: rtl/mem_byte_wr_pkg.sv
// mem_byte_wr shared types: size codes, FSM states, byte-count helper.
package mem_byte_wr_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_e;

  // Bytes-minus-one for a store size; code 3 is treated as a word.
  function automatic logic [1:0] byte_cnt(input logic [1:0] sz);
    logic [1:0] c;
    case (sz)
      SZ_B:    c = 2'd0;
      SZ_H:    c = 2'd1;
      default: c = 2'd3;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_byte_wr.sv
// Byte-serial store engine: one request out as consecutive byte writes.
// MEM_BYTE_WR_LE_EN selects little-endian byte order (default MSB-first).
module mem_byte_wr
  import mem_byte_wr_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_i,
  input  logic [AW-1:0] ad_i,
  input  logic [31:0]   wd_i,
  input  logic [1:0]    sz_i,
  input  logic          mem_stall_i,
  output logic          rdy_o,
  output logic          mem_wr_o,
  output logic [AW-1:0] mem_ad_o,
  output logic [7:0]    mem_dt_o,
  output logic          ok
);

  state_e        state_q, state_d;
  logic [31:0]   sh_q, sh_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [AW-1:0] ad_q, ad_d;
  logic [7:0]    dt_q, dt_d;
  logic          wr_q, wr_d;
  logic          ok_q, ok_d;
  logic [31:0]   ld;

`ifdef MEM_BYTE_WR_LE_EN
  function automatic logic [7:0] cur(input logic [31:0] s);
    return s[7:0];
  endfunction

  function automatic logic [31:0] nxt(input logic [31:0] s);
    return s >> 8;
  endfunction

  assign ld = wd_i;
`else
  function automatic logic [7:0] cur(input logic [31:0] s);
    return s[31:24];
  endfunction

  function automatic logic [31:0] nxt(input logic [31:0] s);
    return s << 8;
  endfunction

  always_comb begin
    ld = wd_i;
    case (sz_i)
      SZ_B:    ld = wd_i << 24;
      SZ_H:    ld = wd_i << 16;
      default: ld = wd_i;
    endcase
  end
`endif

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    ad_d    = ad_q;
    dt_d    = dt_q;
    wr_d    = wr_q;
    ok_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_i) begin
          state_d = S_SEND;
          sh_d    = ld;
          cnt_d   = byte_cnt(sz_i);
          ad_d    = ad_i;
          dt_d    = cur(ld);
          wr_d    = 1'b1;
        end
      end
      S_SEND: begin
        if (!mem_stall_i) begin
          if (cnt_q != 2'd0) begin
            sh_d  = nxt(sh_q);
            cnt_d = cnt_q - 2'd1;
            ad_d  = ad_q + AW'(1);
            dt_d  = cur(sh_d);
          end else begin
            state_d = S_IDLE;
            wr_d    = 1'b0;
            dt_d    = 8'd0;
            ok_d    = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      ad_q    <= '0;
      dt_q    <= '0;
      wr_q    <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      ad_q    <= ad_d;
      dt_q    <= dt_d;
      wr_q    <= wr_d;
      ok_q    <= ok_d;
    end
  end

  assign rdy_o    = (state_q == S_IDLE);
  assign mem_wr_o = wr_q;
  assign mem_ad_o = ad_q;
  assign mem_dt_o = dt_q;
  assign ok       = ok_q;

endmodule

// File: tb/tb_mem_byte_wr.sv
// Randomised scoreboard bench for mem_byte_wr.
// Byte order follows MEM_BYTE_WR_LE_EN like the design.
module tb_mem_byte_wr;

  typedef struct {
    bit          is_ok;
    logic [31:0] ad;
    logic [7:0]  dt;
    int          first;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic [31:0] ad_i;
  logic [31:0] wd_i;
  logic [1:0]  sz_i;
  logic        mem_stall_i;
  logic        rdy_o;
  logic        mem_wr_o;
  logic [31:0] mem_ad_o;
  logic [7:0]  mem_dt_o;
  logic        ok;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int last_acc = 0;
  int hold_n = 0;
  bit rnd_stall = 1'b0;
  bit stall_dir = 1'b0;
  bit wr_prev = 1'b0;
  bit hold_v = 1'b0;
  logic [31:0] hold_ad;
  logic [7:0]  hold_dt;
  exp_t q[$];

  mem_byte_wr #(.AW(32)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .ad_i(ad_i),
    .wd_i(wd_i), .sz_i(sz_i), .mem_stall_i(mem_stall_i),
    .rdy_o(rdy_o), .mem_wr_o(mem_wr_o), .mem_ad_o(mem_ad_o),
    .mem_dt_o(mem_dt_o), .ok(ok)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    mem_stall_i = rnd_stall ? ($urandom_range(0, 3) == 0) : stall_dir;
  end

  task automatic chk(input bit c, input string nm,
                     input longint act, input longint exp);
    checks++;
    if (!c) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Reference: n bytes at a, a+1, ... in the configured order.
  task automatic push_store(input logic [31:0] a, input logic [31:0] wd,
                            input logic [1:0] sz, input int acc);
    int n;
    exp_t e;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int i = 0; i < n; i++) begin
      e.is_ok = 1'b0;
      e.ad    = a + 32'(i);
`ifdef MEM_BYTE_WR_LE_EN
      e.dt    = 8'(wd >> (8 * i));
`else
      e.dt    = 8'(wd >> (8 * (n - 1 - i)));
`endif
      e.first = (i == 0) ? acc + 1 : -1;
      q.push_back(e);
    end
    e.is_ok = 1'b1;
    e.ad    = '0;
    e.dt    = '0;
    e.first = -1;
    q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after acceptance.
  task automatic issue(input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input bit keep);
    bit acc;
    acc = 1'b0;
    req_i = 1'b1;
    ad_i = a;
    wd_i = wd;
    sz_i = sz;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      if (rdy_o) begin
        push_store(a, wd, sz, cyc);
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!acc) chk(1'b0, "accept_timeout", 0, 1);
    if (!keep) req_i = 1'b0;
  endtask

  // Monitor: compares each accepted byte and each ok against the queue.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      wr_prev = 1'b0;
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        hold_n++;
        chk(mem_wr_o && mem_ad_o == hold_ad && mem_dt_o == hold_dt,
            "stall_hold", {mem_ad_o, mem_dt_o}, {hold_ad, hold_dt});
      end
      hold_v = mem_wr_o && mem_stall_i;
      hold_ad = mem_ad_o;
      hold_dt = mem_dt_o;
      if (mem_wr_o && !wr_prev && q.size() != 0)
        chk(q[0].first == cyc, "first_lat", cyc, q[0].first);
      if (mem_wr_o && !mem_stall_i) begin
        if (q.size() == 0 || q[0].is_ok) begin
          chk(1'b0, "unexpected_byte", {mem_ad_o, mem_dt_o}, 0);
        end else begin
          chk(mem_ad_o == q[0].ad && mem_dt_o == q[0].dt, "byte",
              {mem_ad_o, mem_dt_o}, {q[0].ad, q[0].dt});
          void'(q.pop_front());
        end
        last_acc = cyc;
      end
      if (ok) begin
        if (q.size() == 0 || !q[0].is_ok) begin
          chk(1'b0, "unexpected_ok", 1, 0);
        end else begin
          void'(q.pop_front());
          chk(cyc == last_acc + 1, "ok_lat", cyc, last_acc + 1);
        end
        chk(rdy_o && !mem_wr_o, "ok_idle", {rdy_o, mem_wr_o}, 2);
      end
      wr_prev = mem_wr_o;
    end
  end

  initial begin
    int n;
    int h0;
    logic [31:0] a;
    rst = 1'b1;
    req_i = 1'b0;
    ad_i = '0;
    wd_i = '0;
    sz_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(rdy_o && !mem_wr_o && !ok, "reset_ctl",
        {rdy_o, mem_wr_o, ok}, 3'b100);
    chk(mem_ad_o == 0 && mem_dt_o == 0, "reset_data",
        {mem_ad_o, mem_dt_o}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Word store; rdy_o low for exactly four cycles.
    issue(32'h100, 32'hAABBCCDD, 2'd2, 1'b0);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (!rdy_o) n++;
    end
    chk(n == 4, "rdy_low_cycles", n, 4);
    @(posedge clk);
    #1;

    issue(32'h200, 32'h123456EF, 2'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    issue(32'h300, 32'h0000BEEF, 2'd1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    issue(32'h20, 32'hAABBCCDD, 2'd2, 1'b0);
    repeat (6) @(posedge clk);
    #1;

    // Three stall cycles on the second byte.
    h0 = hold_n;
    issue(32'h400, 32'h11223344, 2'd2, 1'b0);
    @(posedge clk);
    #1 stall_dir = 1'b1;
    repeat (3) @(posedge clk);
    #1 stall_dir = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk(hold_n - h0 == 3, "stall_cycles", hold_n - h0, 3);

    // Back-to-back with req_i held through SEND.
    issue(32'h500, 32'hCAFEF00D, 2'd2, 1'b1);
    issue(32'h600, 32'h01020304, 2'd3, 1'b0);
    repeat (7) @(posedge clk);
    #1;

    issue(32'hFFFFFFFE, 32'h55667788, 2'd2, 1'b0);
    repeat (6) @(posedge clk);
    #1;

    // Reset after the second byte has gone out.
    issue(32'h700, 32'h99AABBCC, 2'd2, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk(!mem_wr_o && rdy_o && !ok, "reset_abort",
        {mem_wr_o, rdy_o, ok}, 3'b010);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk(q.size() == 0, "reset_flush", q.size(), 0);

    rnd_stall = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                      : $urandom;
      issue(a, $urandom, 2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end
    req_i = 1'b0;
    for (int k = 0; k < 300 && q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    chk(q.size() == 0 && rdy_o, "drain", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_byte_wr.md
Name: mem_byte_wr

Overview:
- Write-side counterpart of the byte-serial memory reader, which assembles bytes MSB-first into 32-bit words.
- Accepts one store request: start address, 32-bit data and size (byte/half/word).
- Emits the request as consecutive single-byte writes on the 8-bit memory port, incrementing the address each byte.
- Sits between the store path of the MEM stage and the byte-wide RAM port; pulses ok when the store is complete.

Parameters:
- AW, 32, address width of ad_i / mem_ad_o.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- req_i  in  1  store request valid; sampled only while rdy_o=1.
- ad_i  in  AW  start byte address.
- wd_i  in  32  store data; the active bytes are right-aligned.
- sz_i  in  2  size: 0=byte, 1=half, 2=word, 3=word.
- mem_stall_i  in  1  memory busy; the current byte is not accepted this cycle.
- rdy_o  out  1  idle, able to accept a request.
- mem_wr_o  out  1  byte write strobe.
- mem_ad_o  out  AW  byte address.
- mem_dt_o  out  8  byte data.
- ok  out  1  one-cycle pulse, store done.

Behaviour:
- Reset (synchronous, active-high, clk posedge):
  - state=IDLE, rdy_o=1, mem_wr_o=0, mem_ad_o=0, mem_dt_o=0, ok=0.
  - Any in-flight store is aborted with no further bytes emitted.
- States: IDLE, SEND. All outputs are registered; rdy_o = (state==IDLE).
- IDLE with req_i=1:
  - Latch ad_i.
  - Load a 32-bit shift register with wd_i left-aligned: byte wd_i<<24, half wd_i<<16, word wd_i.
  - Load the remaining-byte counter cnt with 0/1/3 (bytes minus 1).
  - Next cycle: state=SEND, mem_wr_o=1, mem_ad_o=ad_i, mem_dt_o=sh[31:24]. First byte appears 1 cycle after acceptance.
- SEND, mem_stall_i=1: hold mem_wr_o, mem_ad_o and mem_dt_o unchanged.
- SEND, mem_stall_i=0, cnt!=0: byte accepted.
  - sh<<=8, mem_ad_o+=1 (mod 2^AW, wrapping 0xFFFFFFFF->0), cnt-=1, mem_dt_o = next byte.
- SEND, mem_stall_i=0, cnt==0: last byte accepted.
  - Next cycle: state=IDLE, mem_wr_o=0, mem_dt_o=0, ok=1 for exactly one cycle.
- Byte order is MSB-first, the exact inverse of the reader: word 0xAABBCCDD -> AA@a, BB@a+1, CC@a+2, DD@a+3.
- Store latency with no stalls: byte=1 cycle, half=2, word=4 write cycles, plus ok on the following cycle.
- ok is asserted in the same cycle rdy_o returns to 1; a req_i in that cycle is accepted, so back-to-back stores have exactly one idle cycle between strobes.
- req_i while in SEND is ignored (not queued); ad_i, wd_i and sz_i are don't-care after acceptance.
- sz_i=3 behaves identically to sz_i=2.
- Reset asserted during SEND: state is IDLE on the next edge, ok is not pulsed.

Optional Feature:
- MEM_BYTE_WR_LE_EN defined:
  - Little-endian order: wd_i is loaded right-aligned, emitted from sh[7:0], and sh>>=8 per byte.
  - Word 0xAABBCCDD -> DD@a, CC@a+1, BB@a+2, AA@a+3; half 0x1234 -> 34@a, 12@a+1.
  - Timing is unchanged.
- Not defined: MSB-first order as above.

Decomposition:
- Shared package holds:
  - size encodings SZ_B=2'd0, SZ_H=2'd1, SZ_W=2'd2;
  - state encoding S_IDLE/S_SEND;
  - a byte-count function for sz -> cnt init.
- No sub-module: the shift register, counter and address incrementer fit in one always block.

Test Plan:
- Word store, no stall: ad_i=0x100, wd_i=0xAABBCCDD, sz=2 -> bytes AA@100, BB@101, CC@102, DD@103 on 4 consecutive cycles; ok the next cycle; rdy_o low for 4 cycles.
- Byte and half stores: sz=0, wd_i=0x123456EF -> single EF@ad_i. sz=1, wd_i=0x0000BEEF -> BE@a, EF@a+1. ok after the last byte in both cases.
- Stall: mem_stall_i high for 3 cycles on the second byte of word 0x11223344 -> 22@a+1 held stable for 4 cycles, no byte lost or duplicated; ok delayed by 3 cycles.
- Back-to-back: req_i held high with two word stores -> second store's first strobe exactly 1 idle cycle after the first store's last byte; req_i during SEND ignored.
- Address wrap and reset: ad_i=0xFFFFFFFE word store -> addresses FFFFFFFE, FFFFFFFF, 0, 1. Reset asserted after the 2nd byte -> mem_wr_o=0 next cycle, no ok, rdy_o=1.
- With MEM_BYTE_WR_LE_EN: word 0xAABBCCDD @0x20 -> DD@20, CC@21, BB@22, AA@23.
